// File: rtl/aes_stream_feeder.sv
// aes_stream_feeder
//   Word-stream front end for AESTOP. Packs four 32-bit input words into a
//   128-bit block (word 0 -> [127:96], word 3 -> [31:0]), latches the mode
//   from word 0, pulses aes_start for one cycle, waits for aes_ready, captures
//   aes_cipher and returns it as four 32-bit words with valid/ready.
//
//   Optional macro AES_FEED_TIMEOUT_EN: WAIT watchdog. If aes_ready is not
//   seen within TIMEOUT_CYC WAIT cycles the block is dropped, err sets (sticky)
//   and the FSM returns to COLLECT. Without the macro err is tied to 0.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   key_wr, key_in, key_ready  key register load (accepted only between blocks)
//   in_valid/in_ready/in_data/in_mode      input word stream
//   out_valid/out_ready/out_data           output word stream
//   aes_start/aes_mode/aes_key/aes_in      drive to AESTOP (registered)
//   aes_cipher/aes_ready                   result from AESTOP
//   blk_done, blk_cnt, err                 status
module aes_stream_feeder #(
   parameter int TIMEOUT_CYC = 64,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             key_wr,
   input  logic [127:0]     key_in,
   output logic             key_ready,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_data,
   input  logic             in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_data,
   output logic             aes_start,
   output logic             aes_mode,
   output logic [127:0]     aes_key,
   output logic [127:0]     aes_in,
   input  logic [127:0]     aes_cipher,
   input  logic             aes_ready,
   output logic             blk_done,
   output logic [CNT_W-1:0] blk_cnt,
   output logic             err
);

   if (TIMEOUT_CYC < 2) begin : g_bad_timeout
      $error("aes_stream_feeder: TIMEOUT_CYC must be >= 2");
   end
   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("aes_stream_feeder: CNT_W must be >= 1");
   end

   typedef enum logic [1:0] {COLLECT, START, WAIT, DRAIN} state_t;

   state_t             state, state_nx;
   logic [1:0]         cnt;
   logic [127:0]       key_q, blk_q, res_q;
   logic               mode_q;
   logic               first_q;   // high in the first WAIT cycle only
   logic [CNT_W-1:0]   blk_cnt_q;
   logic               done_ok;   // AESTOP completion, stale level masked
   logic               timeout;
   logic               in_hs, out_hs;

   assign done_ok   = (state == WAIT) && aes_ready && !first_q;
   assign in_hs     = in_valid && in_ready;
   assign out_hs    = out_valid && out_ready;
   assign key_ready = (state == COLLECT) && (cnt == 2'd0);

   assign aes_key   = key_q;
   assign aes_in    = blk_q;
   assign aes_mode  = mode_q;
   assign blk_cnt   = blk_cnt_q;
   // Word k lives at bits [127-32k -: 32]; ~cnt == 3-cnt for a 2-bit counter.
   assign out_data  = res_q[{~cnt, 5'd0} +: 32];

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      aes_start = 1'b0;
      blk_done  = 1'b0;
      case (state)
         COLLECT: begin
            in_ready = 1'b1;
            if (in_valid && cnt == 2'd3) state_nx = START;
         end
         START: begin
            aes_start = 1'b1;
            state_nx  = WAIT;
         end
         WAIT: begin
            if (done_ok)      state_nx = DRAIN;
            else if (timeout) state_nx = COLLECT;
         end
         DRAIN: begin
            out_valid = 1'b1;
            if (out_ready && cnt == 2'd3) begin
               blk_done = 1'b1;
               state_nx = COLLECT;
            end
         end
         default: state_nx = COLLECT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= COLLECT;
         cnt       <= 2'd0;
         key_q     <= '0;
         blk_q     <= '0;
         res_q     <= '0;
         mode_q    <= 1'b0;
         first_q   <= 1'b0;
         blk_cnt_q <= '0;
      end else begin
         state   <= state_nx;
         first_q <= (state == START);
         // Same-cycle key write and word 0 both land; the new key serves this block.
         if (key_wr && key_ready) key_q <= key_in;
         if (in_hs) begin
            blk_q[{~cnt, 5'd0} +: 32] <= in_data;
            if (cnt == 2'd0) mode_q <= in_mode;
            cnt <= cnt + 2'd1;   // wraps to 0 after word 3
         end
         if (done_ok) res_q <= aes_cipher;
         if (out_hs) begin
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) blk_cnt_q <= blk_cnt_q + 1'b1;
         end
      end
   end

`ifdef AES_FEED_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

   logic [WD_W-1:0] wd_q;
   logic            err_q;

   assign timeout = (state == WAIT) && !done_ok && (wd_q == WD_W'(TIMEOUT_CYC - 1));
   assign err     = err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_q  <= '0;
         err_q <= 1'b0;
      end else begin
         if (state == WAIT) wd_q <= wd_q + 1'b1;
         else               wd_q <= '0;
         if (timeout) err_q <= 1'b1;
      end
   end
`else
   assign timeout = 1'b0;
   assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_aes_stream_feeder.sv
// Bench for aes_stream_feeder. AESTOP is replaced by a stand-in with
// programmable latency and a reversible toy transform; the stand-in keeps a
// stale high aes_ready (with the old result) until one cycle after each start.
module tb_aes_stream_feeder;
   localparam int CNT_W = 16;

   logic             clk = 1'b0, rst_n = 1'b0;
   logic             key_wr = 1'b0;
   logic [127:0]     key_in = '0;
   logic             key_ready;
   logic             in_valid = 1'b0, in_ready;
   logic [31:0]      in_data = '0;
   logic             in_mode = 1'b0;
   logic             out_valid, out_ready = 1'b1;
   logic [31:0]      out_data;
   logic             aes_start, aes_mode, aes_ready;
   logic [127:0]     aes_key, aes_in, aes_cipher;
   logic             blk_done, err;
   logic [CNT_W-1:0] blk_cnt;

   int tests = 0, fails = 0;

   always #5 clk = ~clk;

   aes_stream_feeder #(.TIMEOUT_CYC(64), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .key_wr(key_wr), .key_in(key_in), .key_ready(key_ready),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .aes_start(aes_start), .aes_mode(aes_mode), .aes_key(aes_key), .aes_in(aes_in),
      .aes_cipher(aes_cipher), .aes_ready(aes_ready),
      .blk_done(blk_done), .blk_cnt(blk_cnt), .err(err));

   // toy cipher: encrypt = rotate-left-by-byte then xor key; decrypt inverts it
   function automatic logic [127:0] mock_f(input logic [127:0] x, input logic [127:0] k,
                                           input logic m);
      logic [127:0] t;
      if (!m) return {x[119:0], x[127:120]} ^ k;
      t = x ^ k;
      return {t[7:0], t[127:8]};
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- AESTOP stand-in ----------------
   int  lat  = 2;
   bit  hang = 1'b0;
   bit  mk_busy, mk_arm;
   int  mk_cnt;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aes_ready <= 1'b0; aes_cipher <= '0; mk_busy <= 1'b0; mk_arm <= 1'b0; mk_cnt <= 0;
      end else if (aes_start) begin
         mk_busy <= 1'b1; mk_arm <= 1'b1; mk_cnt <= lat;
      end else if (mk_busy) begin
         if (mk_arm) begin
            mk_arm <= 1'b0; aes_ready <= 1'b0;
         end else if (!hang) begin
            if (mk_cnt > 1) mk_cnt <= mk_cnt - 1;
            else begin
               // result taken from the live drive: catches any drift during WAIT
               aes_ready  <= 1'b1;
               aes_cipher <= mock_f(aes_in, aes_key, aes_mode);
               mk_busy    <= 1'b0;
            end
         end
      end
   end

   // ---------------- reference model / monitor ----------------
   logic [127:0] m_key, m_blkkey;
   logic         m_mode;
   logic [31:0]  m_words[$];
   logic [31:0]  expq[$];
   logic [31:0]  got[$];
   bit           ref_busy = 1'b0;
   int           m_blks = 0, starts = 0;
   bit           mon_en = 1'b1, seen_ov = 1'b0;
   bit           prev_stall = 1'b0, prev_start = 1'b0;
   logic [31:0]  prev_data;

   always @(negedge clk) begin : mon
      bit           busy_now, kr, last;
      logic [127:0] b, r;
      if (out_valid) seen_ov = 1'b1;
      if (!rst_n) begin
         m_key = '0; m_words.delete(); expq.delete(); ref_busy = 1'b0; m_blks = 0;
         prev_stall = 1'b0; prev_start = 1'b0;
      end else if (mon_en) begin
         busy_now = ref_busy;
         kr       = !busy_now && m_words.size() == 0;
         chk("in_ready", in_ready, !busy_now);
         chk("key_ready", key_ready, kr);
         chk("err", err, 1'b0);
         chk("blk_cnt", blk_cnt, m_blks[CNT_W-1:0]);
         if (!busy_now) chk("out_valid_idle", out_valid, 1'b0);
         if (prev_stall) chk("out_hold", out_data, prev_data);
         last = out_valid && out_ready && busy_now && expq.size() == 1;
         chk("blk_done", blk_done, last);
         if (aes_start) begin
            starts++;
            chk("start_width", prev_start, 1'b0);
            chk("start_busy", busy_now, 1'b1);
         end
         if (out_valid && out_ready) begin
            if (expq.size() == 0) chk("out_extra", out_data, 32'hx);
            else begin
               chk("out_data", out_data, expq[0]);
               got.push_back(out_data);
               void'(expq.pop_front());
               if (expq.size() == 0) begin ref_busy = 1'b0; m_blks++; end
            end
         end
         if (key_wr && kr) m_key = key_in;
         if (in_valid && !busy_now) begin
            if (m_words.size() == 0) begin m_mode = in_mode; m_blkkey = m_key; end
            m_words.push_back(in_data);
            if (m_words.size() == 4) begin
               b = {m_words[0], m_words[1], m_words[2], m_words[3]};
               r = mock_f(b, m_blkkey, m_mode);
               expq.push_back(r[127:96]); expq.push_back(r[95:64]);
               expq.push_back(r[63:32]);  expq.push_back(r[31:0]);
               m_words.delete();
               ref_busy = 1'b1;
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         prev_start = aes_start;
      end
   end

   // ---------------- drivers ----------------
   task automatic tick(); @(posedge clk); #1; endtask

   task automatic send_word(input logic [31:0] w, input logic m);
      bit ok = 1'b0;
      in_data = w; in_mode = m; in_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (in_ready) begin ok = 1'b1; break; end
      end
      if (!ok) chk("in_accept_timeout", 1'b0, 1'b1);
      tick();
   endtask

   // words 1-3 carry the opposite mode to show it is ignored
   task automatic send_block(input logic [127:0] b, input logic m);
      for (int i = 0; i < 4; i++) send_word(b[127-32*i -: 32], (i == 0) ? m : ~m);
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(posedge clk);
         if (!ref_busy) begin ok = 1'b1; break; end
      end
      #1;
      if (!ok) chk("drain_timeout", 1'b0, 1'b1);
   endtask

   task automatic write_key(input logic [127:0] k);
      key_in = k; key_wr = 1'b1; tick(); key_wr = 1'b0;
   endtask

   typedef struct {
      logic [127:0] key;
      logic [127:0] blk;
      logic         mode;
      logic [127:0] exp;
   } vec_t;

   localparam logic [127:0] K  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] P  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C  = 128'h112331475163718f91a3b1c7d1e3f10f;
   localparam logic [127:0] K2 = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

   initial begin : watchdog
      #900000;
      fails++;
      $display("FAIL global_timeout: simulation ran past its time limit");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "global timeout");
   end

   initial begin : main
      vec_t             tbl[4];
      logic [3:0]       pat;
      logic [127:0]     r;
      int               s0, b0, p;
      logic [CNT_W-1:0] bc;

      tbl[0] = '{128'h0, P, 1'b0, 128'h112233445566778899aabbccddeeff00};
      tbl[1] = '{K, P, 1'b0, C};
      tbl[2] = '{K, C, 1'b1, P};
      tbl[3] = '{128'h0, 128'h112233445566778899aabbccddeeff00, 1'b1, P};

      // reset values
      rst_n = 1'b0;
      tick(); tick();
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_key_ready", key_ready, 1'b1);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_aes_start", aes_start, 1'b0);
      chk("rst_blk_done", blk_done, 1'b0);
      chk("rst_blk_cnt", blk_cnt, '0);
      chk("rst_err", err, 1'b0);
      chk("rst_aes_key", aes_key, '0);
      chk("rst_aes_in", aes_in, '0);
      chk("rst_aes_mode", aes_mode, 1'b0);
      chk("rst_out_data", out_data, '0);
      rst_n = 1'b1;
      tick();

      // table vectors (later rows also see a stale aes_ready from the row before)
      for (int v = 0; v < 4; v++) begin
         bc = blk_cnt;
         write_key(tbl[v].key);
         got.delete();
         send_block(tbl[v].blk, tbl[v].mode);
         wait_idle();
         chk("tbl_nwords", got.size(), 4);
         for (int i = 0; i < 4 && i < got.size(); i++)
            chk($sformatf("tbl%0d_w%0d", v, i), got[i], tbl[v].exp[127-32*i -: 32]);
         chk("tbl_blk_cnt", blk_cnt, bc + 1'b1);
      end

      // backpressure: out_ready 1,0,0,1,...
      pat = 4'b1001; p = 0;
      got.delete();
      write_key(K);
      send_block(P, 1'b0);
      for (int i = 0; i < 100 && ref_busy; i++) begin
         out_ready = pat[3 - (p % 4)]; p++;
         tick();
      end
      out_ready = 1'b1;
      wait_idle();
      chk("bp_nwords", got.size(), 4);
      if (got.size() == 4) chk("bp_w0", got[0], C[127:96]);

      // key write during WAIT is dropped
      lat = 6;
      got.delete();
      send_block(P, 1'b0);
      tick(); tick(); tick();
      key_in = '1; key_wr = 1'b1;
      @(negedge clk);
      chk("keyrdy_wait", key_ready, 1'b0);
      tick();
      key_wr = 1'b0;
      wait_idle();
      if (got.size() == 4) chk("keygate_w3", got[3], C[31:0]);
      else chk("keygate_nwords", got.size(), 4);

      // key write together with word 0 applies to that block
      got.delete();
      key_in = K2; key_wr = 1'b1;
      send_word(P[127:96], 1'b1);
      key_wr = 1'b0;
      for (int i = 1; i < 4; i++) send_word(P[127-32*i -: 32], 1'b0);
      in_valid = 1'b0;
      wait_idle();
      r = mock_f(P, K2, 1'b1);
      if (got.size() == 4) chk("newkey_w0", got[0], r[127:96]);
      else chk("newkey_nwords", got.size(), 4);

      // back-to-back, valid held high
      s0 = starts; b0 = m_blks;
      for (int b = 0; b < 10; b++) begin
         lat = $urandom_range(1, 4);
         for (int i = 0; i < 4; i++) send_word($urandom, 1'($urandom));
      end
      in_valid = 1'b0;
      wait_idle();
      chk("b2b_starts", starts - s0, 10);
      chk("b2b_blocks", m_blks - b0, 10);

      // reset after two words, then a fresh block
      send_word(32'hdeadbeef, 1'b1);
      send_word(32'hcafef00d, 1'b1);
      in_valid = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("mrst_out_valid", out_valid, 1'b0);
      chk("mrst_in_ready", in_ready, 1'b1);
      chk("mrst_blk_cnt", blk_cnt, '0);
      got.delete();
      send_block(P, 1'b0);
      wait_idle();
      r = mock_f(P, 128'h0, 1'b0);
      if (got.size() == 4) chk("mrst_w2", got[2], r[63:32]);
      else chk("mrst_nwords", got.size(), 4);

      // random soak
      for (int c = 0; c < 1500; c++) begin
         in_valid  = ($urandom % 3) != 0;
         in_data   = $urandom;
         in_mode   = 1'($urandom);
         out_ready = 1'($urandom);
         key_wr    = ($urandom % 8) == 0;
         key_in    = {$urandom, $urandom, $urandom, $urandom};
         lat       = $urandom_range(1, 5);
         tick();
      end
      in_valid = 1'b0; key_wr = 1'b0; out_ready = 1'b1;
      wait_idle();

`ifdef AES_FEED_TIMEOUT_EN
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      mon_en = 1'b0; hang = 1'b1; seen_ov = 1'b0;
      send_block(P, 1'b0);
      for (int i = 0; i < 100 && !err; i++) tick();
      chk("to_err", err, 1'b1);
      tick(); tick();
      chk("to_in_ready", in_ready, 1'b1);
      chk("to_err_sticky", err, 1'b1);
      chk("to_no_out_valid", seen_ov, 1'b0);
      chk("to_blk_cnt", blk_cnt, '0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/aes_stream_feeder.md
Name: aes_stream_feeder

Overview:
- Word-stream front end for AESTOP.
- Packs four 32-bit input words into one 128-bit block and latches the encrypt/decrypt mode for that block.
- Issues a single-cycle start to AESTOP, waits for its ready, then captures the 128-bit result.
- Returns the result as four 32-bit output words with valid/ready flow control. Sits between the bus/DMA side and AESTOP.

Parameters:
- TIMEOUT_CYC, 64: maximum cycles from start to AESTOP ready before a watchdog error. Used only with AES_FEED_TIMEOUT_EN.
- CNT_W, 16: width of the completed-block counter.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- key_wr  in  1  load key_in into the key register
- key_in  in  128  AES-128 key
- key_ready  out  1  high when a key write is accepted
- in_valid  in  1  input word valid
- in_ready  out  1  input word accepted when in_valid&in_ready
- in_data  in  32  input word
- in_mode  in  1  0 encrypt, 1 decrypt; sampled with word 0 of a block
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts the word
- out_data  out  32  output word
- aes_start  out  1  to AESTOP i_start
- aes_mode  out  1  to AESTOP mode
- aes_key  out  128  to AESTOP i_key
- aes_in  out  128  to AESTOP i_in
- aes_cipher  in  128  from AESTOP o_cipher
- aes_ready  in  1  from AESTOP o_ready
- blk_done  out  1  one-cycle pulse when the last output word is accepted
- blk_cnt  out  CNT_W  completed blocks; wraps at 2^CNT_W
- err  out  1  sticky watchdog error; constant 0 without the feature

Behaviour:
- Reset (asynchronous, rst_n=0): state COLLECT; word counter 0; in_ready=1; out_valid=0; aes_start=0; blk_done=0; blk_cnt=0; err=0; key, block, mode and result registers cleared to 0.
- Byte order: word 0 maps to bits [127:96], word 3 to bits [31:0], for both input and output. This matches the hex pattern files.
- FSM states: COLLECT, START, WAIT, DRAIN.
- COLLECT:
  - in_ready=1.
  - Each handshake writes in_data into its slot and increments the word counter.
  - in_mode is latched on word 0 only; in_mode on words 1-3 is ignored.
  - After the 4th word: counter returns to 0, go to START.
- START:
  - aes_start=1 for exactly one cycle; in_ready=0. Go to WAIT.
- WAIT:
  - aes_ready is ignored in the first WAIT cycle (the cycle after the start pulse), so a stale high level from the previous block is not taken as completion.
  - From the second WAIT cycle on, the first cycle with aes_ready=1 captures aes_cipher into the result register and moves to DRAIN.
- DRAIN:
  - out_valid=1; out_data = result word selected by the counter.
  - The counter advances on each out_valid&out_ready.
  - out_data must hold stable while out_valid=1 and out_ready=0.
  - After the 4th word is accepted: blk_done pulses, blk_cnt increments, counter returns to 0, go to COLLECT.
- Static AESTOP drive: aes_key, aes_in and aes_mode come straight from registers and must not change from START through the end of WAIT.
- Key register:
  - key_ready = (state==COLLECT && word counter==0).
  - key_wr while key_ready=1 loads the key in that cycle.
  - key_wr while key_ready=0 is dropped with no side effect.
  - If key_wr and an in_data handshake for word 0 occur in the same cycle, both take effect, and the new key applies to this block.
- Latency with continuous valid/ready: 4 collect cycles, 1 start cycle, AESTOP latency + 1, then 4 drain cycles.
- There is no overlap between blocks; in_ready=0 outside COLLECT.
- Reset asserted mid-block discards the partial block and any result in flight; no stale out_valid after release.

Optional Feature:
- Macro: AES_FEED_TIMEOUT_EN.
- Defined: a watchdog counts WAIT cycles. If aes_ready is not seen within TIMEOUT_CYC cycles:
  - err sets and stays set until reset.
  - The FSM returns to COLLECT with the block dropped: no out_valid, no blk_done, blk_cnt unchanged.
- Not defined: WAIT lasts indefinitely; err is tied to 0; no watchdog logic is present.

Test Plan:
- FIPS-197 encrypt: key 000102030405060708090a0b0c0d0e0f, words 00112233,44556677,8899aabb,ccddeeff with mode 0 -> outputs 69c4e0d8,6a7b0430,d8cdb780,70b4c55a in order; blk_done once; blk_cnt=1.
- Decrypt: same key, words 69c4e0d8..70b4c55a with mode 1 -> outputs 00112233..ccddeeff.
- Backpressure: out_ready toggles 1,0,0,1,... during DRAIN -> no word dropped or duplicated; out_data stable while stalled; in_ready=0 throughout.
- Key gating: key_wr with key ffff...ff during WAIT -> ignored and result unchanged; key_wr in COLLECT with word counter 0 -> the next block uses the new key.
- Back-to-back: the 10 vectors from full_input/full_key/full_cipher streamed with in_valid held high -> all 10 match; blk_cnt=10; aes_start pulses exactly 10 times, each one cycle wide.
- Reset and timeout:
  - rst_n low after word 2 -> the next 4 words form a fresh block with a correct result.
  - With AES_FEED_TIMEOUT_EN, aes_ready held 0 -> err=1 after 64 cycles; FSM back in COLLECT; out_valid never asserted.
